// File: rtl/imem_responder.sv
// Instruction-memory responder: 1-cycle fetch reads, byte-enabled data writes,
// and a byte-stream program loader that stalls the core's ports while it runs.
module imem_responder #(
  parameter int ADDR_WIDTH     = 16,
  parameter int MEM_WORDS      = 4096,
  parameter int LOAD_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rd_ram_en,
  input  logic [ADDR_WIDTH-1:0]     rd_ram_addr,
  output logic [31:0]               rd_ram_data,
  output logic                      rd_ram_valid,
  input  logic                      wr_ram_en,
  input  logic [31:0]               wr_ram_addr,
  input  logic [31:0]               wr_ram_data,
  input  logic [3:0]                wr_ram_be,
  output logic                      wr_drop,
  input  logic                      load_start,
  input  logic [ADDR_WIDTH-1:0]     load_base,
  input  logic [LOAD_CNT_WIDTH-1:0] load_words,
  input  logic                      load_valid,
  input  logic [7:0]                load_byte,
  output logic                      load_ready,
  output logic                      load_done,
  output logic                      busy
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                    state, state_nxt;
  logic [1:0]                byte_idx;
  logic [LOAD_CNT_WIDTH-1:0] word_cnt, word_tgt;
  logic [IDX_W-1:0]          ld_ptr;
  logic [23:0]               ld_asm;
  logic                      ld_fire;
  logic                      zero_done;
  logic [31:0]               mem [MEM_WORDS];

  logic [ADDR_WIDTH-3:0] rd_word, wr_word;
  logic rd_hit, wr_ok, wr_req, wr_do, wr_bad, ld_start;
  logic unused_bits;

  assign rd_word  = rd_ram_addr[ADDR_WIDTH-1:2];
  assign wr_word  = wr_ram_addr[ADDR_WIDTH-1:2];
  assign rd_hit   = 32'(rd_word) < 32'(MEM_WORDS);
  assign wr_ok    = (wr_ram_addr[31:ADDR_WIDTH] == '0) && (32'(wr_word) < 32'(MEM_WORDS));
  // An all-zero byte enable is a harmless no-op, so it never counts as dropped.
  assign wr_req   = wr_ram_en && (wr_ram_be != 4'b0000);
  assign wr_do    = wr_req && wr_ok && !busy;
  assign wr_bad   = wr_req && !(wr_ok && !busy);
  assign ld_start = (state == IDLE) && load_start;

  assign load_done   = (state == DONE) || zero_done;
  assign unused_bits = ^{rd_ram_addr[1:0], wr_ram_addr[1:0], load_base[1:0],
                         load_base[ADDR_WIDTH-1:IDX_W+2]};

  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    busy       = 1'b0;
    ld_fire    = 1'b0;
    case (state)
      IDLE: begin
        if (load_start && (load_words != '0)) state_nxt = LOAD;
      end
      LOAD: begin
        load_ready = 1'b1;
        busy       = 1'b1;
        if (load_valid && (byte_idx == 2'd3)) begin
          ld_fire = 1'b1;
          if (word_cnt + 1'b1 == word_tgt) state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      byte_idx     <= 2'd0;
      word_cnt     <= '0;
      rd_ram_valid <= 1'b0;
      rd_ram_data  <= 32'h0;
      wr_drop      <= 1'b0;
      zero_done    <= 1'b0;
    end else begin
      state        <= state_nxt;
      rd_ram_valid <= rd_ram_en && !busy;
      if (rd_ram_en && !busy) rd_ram_data <= rd_hit ? mem[rd_word[IDX_W-1:0]] : NOP;
      wr_drop      <= wr_bad;
      zero_done    <= ld_start && (load_words == '0);
      if (ld_start) begin
        byte_idx <= 2'd0;
        word_cnt <= '0;
      end else if ((state == LOAD) && load_valid) begin
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) word_cnt <= word_cnt + 1'b1;
      end
    end
  end

  // Loader datapath and memory array carry no reset; a reset mid-load simply
  // abandons the partial word in ld_asm.
  always_ff @(posedge clk) begin
    if (ld_start) begin
      word_tgt <= load_words;
      ld_ptr   <= load_base[IDX_W+1:2];
    end else if (ld_fire) begin
      ld_ptr <= ld_ptr + 1'b1;
    end
    if ((state == LOAD) && load_valid) begin
      case (byte_idx)
        2'd0:    ld_asm[7:0]   <= load_byte;
        2'd1:    ld_asm[15:8]  <= load_byte;
        2'd2:    ld_asm[23:16] <= load_byte;
        default: ;
      endcase
    end
    if (ld_fire) begin
      mem[ld_ptr] <= {load_byte, ld_asm};
    end else if (wr_do) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_ram_be[i]) mem[wr_word[IDX_W-1:0]][8*i +: 8] <= wr_ram_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: loader, fetch, byte writes, drops, wrap and reset abort.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_ram_en;
  logic [15:0] rd_ram_addr;
  logic [31:0] rd_ram_data;
  logic        rd_ram_valid;
  logic        wr_ram_en;
  logic [31:0] wr_ram_addr;
  logic [31:0] wr_ram_data;
  logic [3:0]  wr_ram_be;
  logic        wr_drop;
  logic        load_start;
  logic [15:0] load_base;
  logic [15:0] load_words;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_ready;
  logic        load_done;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  imem_responder dut (
    .clk(clk), .reset(reset),
    .rd_ram_en(rd_ram_en), .rd_ram_addr(rd_ram_addr),
    .rd_ram_data(rd_ram_data), .rd_ram_valid(rd_ram_valid),
    .wr_ram_en(wr_ram_en), .wr_ram_addr(wr_ram_addr),
    .wr_ram_data(wr_ram_data), .wr_ram_be(wr_ram_be), .wr_drop(wr_drop),
    .load_start(load_start), .load_base(load_base), .load_words(load_words),
    .load_valid(load_valid), .load_byte(load_byte), .load_ready(load_ready),
    .load_done(load_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [15:0] addr, input logic [31:0] exp, input string tag);
    rd_ram_en = 1'b1;
    rd_ram_addr = addr;
    tick();
    rd_ram_en = 1'b0;
    chk({tag, "_vld"}, rd_ram_valid, 1);
    chk(tag, rd_ram_data, exp);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    wr_ram_en = 1'b1;
    wr_ram_addr = addr;
    wr_ram_data = data;
    wr_ram_be = be;
    tick();
    wr_ram_en = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] base, input logic [15:0] n,
                         input logic [95:0] data, input bit poke, input string tag);
    load_start = 1'b1;
    load_base = base;
    load_words = n;
    tick();
    load_start = 1'b0;
    chk({tag, "_busy_on"}, busy, 1);
    chk({tag, "_ready_on"}, load_ready, 1);
    for (int j = 0; j < 4 * n; j++) begin
      load_byte = data[8*j +: 8];
      load_valid = 1'b1;
      if (poke && j == 0) begin
        rd_ram_en = 1'b1; rd_ram_addr = 16'h0008;
        wr_ram_en = 1'b1; wr_ram_addr = 32'h8; wr_ram_data = 32'h0; wr_ram_be = 4'hF;
        load_start = 1'b1; load_base = 16'h0100; load_words = 16'd0;
      end
      tick();
      load_valid = 1'b0; rd_ram_en = 1'b0; wr_ram_en = 1'b0; load_start = 1'b0;
      if (poke && j == 0) begin
        chk({tag, "_rd_stalled"}, rd_ram_valid, 0);
        chk({tag, "_wr_drop"}, wr_drop, 1);
      end
      if (j == 0) chk({tag, "_no_early_done"}, load_done, 0);
      if (j == 1) begin
        tick();
        chk({tag, "_gap_ready"}, load_ready, 1);
        chk({tag, "_gap_busy"}, busy, 1);
      end
    end
    chk({tag, "_done"}, load_done, 1);
    chk({tag, "_done_busy"}, busy, 1);
    chk({tag, "_done_ready"}, load_ready, 0);
    tick();
    chk({tag, "_done_off"}, load_done, 0);
    chk({tag, "_busy_off"}, busy, 0);
  endtask

  initial begin
    reset = 1'b1;
    rd_ram_en = 1'b0; rd_ram_addr = '0;
    wr_ram_en = 1'b0; wr_ram_addr = '0; wr_ram_data = '0; wr_ram_be = '0;
    load_start = 1'b0; load_base = '0; load_words = '0;
    load_valid = 1'b0; load_byte = '0;
    tick();
    tick();
    chk("rst_rd_data", rd_ram_data, 0);
    chk("rst_rd_valid", rd_ram_valid, 0);
    chk("rst_wr_drop", wr_drop, 0);
    chk("rst_ready", load_ready, 0);
    chk("rst_done", load_done, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    tick();

    do_load(16'h0000, 16'd2, {32'h0, 32'h00100093, 32'h00500013}, 1'b0, "ld1");
    rd(16'h0000, 32'h00500013, "rd_w0");
    rd(16'h0004, 32'h00100093, "rd_w1");
    rd(16'h0006, 32'h00100093, "rd_lowbits");
    rd(16'h4000, 32'h00000013, "rd_oor_nop");
    tick();
    chk("idle_vld", rd_ram_valid, 0);
    chk("idle_hold", rd_ram_data, 32'h00000013);

    wr(32'h8, 32'hAABBCCDD, 4'hF);
    chk("wr_full_drop", wr_drop, 0);
    rd_ram_en = 1'b1; rd_ram_addr = 16'h0008;
    wr(32'h8, 32'h11223344, 4'b0101);
    rd_ram_en = 1'b0;
    chk("rbw_old", rd_ram_data, 32'hAABBCCDD);
    chk("wr_be_drop", wr_drop, 0);
    rd(16'h0008, 32'hAA22CC44, "rd_be_merge");
    wr(32'h4000, 32'hFFFFFFFF, 4'hF);
    chk("wr_oor_drop", wr_drop, 1);
    wr(32'h10008, 32'hFFFFFFFF, 4'hF);
    chk("wr_hi_drop", wr_drop, 1);
    wr(32'h8, 32'hFFFFFFFF, 4'h0);
    chk("wr_be0_drop", wr_drop, 0);
    rd(16'h0008, 32'hAA22CC44, "rd_after_drops");

    load_start = 1'b1; load_base = 16'h0040; load_words = 16'd0;
    tick();
    load_start = 1'b0;
    chk("zero_busy", busy, 0);
    chk("zero_done", load_done, 1);
    tick();
    chk("zero_done_off", load_done, 0);

    do_load(16'h0010, 16'd1, {64'h0, 32'hDEADBEEF}, 1'b1, "ld_poke");
    rd(16'h0008, 32'hAA22CC44, "rd_poke_kept");
    rd(16'h0010, 32'hDEADBEEF, "rd_poke_word");

    do_load(16'h3FFC, 16'd3, {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001}, 1'b0, "ld_wrap");
    rd(16'h3FFC, 32'hCAFE0001, "rd_wrap_4095");
    rd(16'h0000, 32'hCAFE0002, "rd_wrap_0");
    rd(16'h0004, 32'hCAFE0003, "rd_wrap_1");
    rd(16'h0008, 32'hAA22CC44, "rd_wrap_2_kept");

    wr(32'h20, 32'h12345678, 4'hF);
    wr(32'h24, 32'h9ABCDEF0, 4'hF);
    load_start = 1'b1; load_base = 16'h0020; load_words = 16'd2;
    tick();
    load_start = 1'b0;
    for (int j = 0; j < 6; j++) begin
      load_byte = (j < 4) ? ((j == 0) ? 8'h01 : 8'h0A) : 8'h0B;
      load_valid = 1'b1;
      tick();
    end
    load_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_ready", load_ready, 0);
    chk("abort_done", load_done, 0);
    chk("abort_rd_data", rd_ram_data, 0);
    reset = 1'b0;
    tick();
    chk("abort_no_done", load_done, 0);
    chk("abort_idle_busy", busy, 0);
    rd(16'h0020, 32'h0A0A0A01, "rd_abort_w0");
    rd(16'h0024, 32'h9ABCDEF0, "rd_abort_w1");
    do_load(16'h0024, 16'd1, {64'h0, 32'h55667788}, 1'b0, "ld_after_abort");
    rd(16'h0024, 32'h55667788, "rd_after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Memory-side responder for the core's instruction-fetch read port and data write port.
- Serves fetch reads with fixed 1-cycle latency.
- Applies byte-enabled word writes.
- Contains a byte-stream program loader FSM that fills memory from an external host before or between runs. While loading, the block stalls fetches.
- Sits between the execution unit's RAM ports and the board-level host link.

Parameters:
- ADDR_WIDTH, 16, byte-address width of the fetch port. Word index = addr[ADDR_WIDTH-1:2].
- MEM_WORDS, 4096, number of 32-bit words implemented.
- LOAD_CNT_WIDTH, 16, width of the loader word-count input.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- rd_ram_en  in  1  fetch read request
- rd_ram_addr  in  ADDR_WIDTH  fetch byte address
- rd_ram_data  out  32  fetch read data
- rd_ram_valid  out  1  rd_ram_data holds the response to the request of the previous cycle
- wr_ram_en  in  1  data write request
- wr_ram_addr  in  32  data write byte address
- wr_ram_data  in  32  data write value
- wr_ram_be  in  4  byte enables, bit i -> bits [8i+7:8i]
- wr_drop  out  1  one-cycle pulse: a write was discarded
- load_start  in  1  start loader (sampled only in IDLE)
- load_base  in  ADDR_WIDTH  loader start byte address, word aligned
- load_words  in  LOAD_CNT_WIDTH  number of words to load
- load_valid  in  1  load_byte valid
- load_byte  in  8  stream byte, little-endian within a word
- load_ready  out  1  loader accepts a byte this cycle
- load_done  out  1  one-cycle pulse: last word written
- busy  out  1  loader active

Behaviour:
- Reset:
  - rd_ram_data=0, rd_ram_valid=0, wr_drop=0, load_ready=0, load_done=0, busy=0.
  - FSM=IDLE; byte index and word counter cleared.
  - Memory contents are not cleared.
  - Reset mid-load aborts the load. Words already written are retained. A partially assembled word is discarded.
- Fetch read:
  - In IDLE, rd_ram_en=1 at edge N gives rd_ram_data = mem[word] and rd_ram_valid=1 after edge N+1.
  - rd_ram_en=0 gives rd_ram_valid=0, and rd_ram_data holds its last value.
  - rd_ram_addr[1:0] is ignored.
  - Word index >= MEM_WORDS returns 32'h0000_0013 (NOP).
- Write:
  - wr_ram_en=1 writes only the enabled bytes of mem[wr_ram_addr[ADDR_WIDTH-1:2]]. wr_ram_addr bits above ADDR_WIDTH-1 must be zero.
  - An out-of-range write, or any write while busy=1, is discarded and pulses wr_drop the following cycle.
  - wr_ram_be=0 is a legal no-op with no wr_drop.
- Same-cycle read and write to the same word: the read returns old data (read-before-write). The new data is visible on the next read.
- FSM:
  - IDLE: load_ready=0, busy=0.
    - load_start=1 with load_words=0: stay IDLE, pulse load_done next cycle.
    - load_start=1 with load_words>0: latch base and count, go LOAD. busy=1 from the next cycle.
  - LOAD: load_ready=1.
    - Each load_valid&load_ready accepts a byte into lane byte_idx. byte_idx increments mod 4.
    - On the 4th byte: write the full word to mem[base_word+k], k++, byte_idx=0.
    - When k reaches load_words: go DONE.
    - The word address wraps modulo MEM_WORDS.
    - Fetch requests get rd_ram_valid=0. Data writes are dropped.
  - DONE (1 cycle): load_ready=0, load_done=1, busy=1. Then go IDLE.
  - load_start is ignored outside IDLE.
  - A gap in load_valid stalls the loader with no timeout.
- Width rules: the word counter compares at LOAD_CNT_WIDTH. The base word index is computed modulo MEM_WORDS (power of two).

Test Plan:
- Reset, then load_start with base=0x0000, words=2, bytes 13 00 50 00 93 00 10 00 -> mem[0]=0x00500013, mem[1]=0x00100093; load_done pulses once; busy falls one cycle after load_done.
- Fetch rd_ram_addr=0x0004 in IDLE -> next cycle rd_ram_valid=1, rd_ram_data=0x00100093. Fetch rd_ram_addr=0x4000 with MEM_WORDS=4096 -> 0x00000013.
- mem[2]=0xAABBCCDD; write addr 0x8, data 0x11223344, be=4'b0101 -> read gives 0xAA22CC44. Same-cycle read of 0x8 returns 0xAABBCCDD.
- During LOAD, rd_ram_en=1 -> rd_ram_valid=0. wr_ram_en=1 -> memory unchanged, wr_drop=1 next cycle.
- Load words=3 at base=0x3FFC (word 4095) -> writes land in words 4095, 0, 1 (wrap).
- Assert reset after 6 bytes of a 2-word load -> word 0 written, word 1 unchanged, FSM IDLE, busy=0, no load_done.
